serial_adder_hs: RTL and testbench
==================================

// Module: serial_adder_hs
// PURPOSE
//   Parametrised digit-serial adder: the multi-bit, clocked successor to the single-bit half adder.
//   Accepts two WIDTH-bit operands plus carry-in over a valid/ready handshake.
//   Adds them DIGIT bits per cycle through a registered carry.
//   Returns sum, carry-out and signed overflow over a second valid/ready handshake.
//   Sits between the ui_in/uio_in operand capture logic and the uo_out result mux of the top wrapper.
// PARAMETERS
//   WIDTH  8  operand/sum width in bits; >=2
//   DIGIT  1  bits added per cycle; must divide WIDTH; NDIG = WIDTH/DIGIT
// PORTS
//   clk        in   1      clock, all state on rising edge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      operands valid
//   in_ready   out  1      block can accept operands
//   in_a       in   WIDTH  operand A
//   in_b       in   WIDTH  operand B
//   in_cin     in   1      carry-in
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer accepts result
//   out_sum    out  WIDTH  A+B+cin mod 2^WIDTH
//   out_cout   out  1      carry out of bit WIDTH-1
//   out_ovf    out  1      two's-complement overflow
//   busy       out  1      high in RUN
// BEHAVIOUR
//   Reset: one cycle of rst=1 forces the following, regardless of state.
//     - FSM goes to IDLE; digit counter, carry register and shift registers are cleared to 0.
//     - out_valid=0, out_sum=0, out_cout=0, out_ovf=0, busy=0, in_ready=0.
//   in_ready is combinational: 1 in IDLE and rst=0.
//   FSM states: IDLE, RUN, DONE.
//   IDLE
//     - On in_valid&in_ready: latch A and B into shift registers; carry := in_cin; cnt := 0.
//     - Then go to RUN.
//   RUN (one cycle per digit)
//     - {c,s} = A[DIGIT-1:0] + B[DIGIT-1:0] + carry.
//     - Shift A and B right by DIGIT; carry := c.
//     - Shift s into the sum register from the MSB end; cnt++.
//     - On the digit where cnt==NDIG-1:
//         * capture cout = c;
//         * ovf = carry into MSB ^ c (from the MSB bit of that digit);
//         * go to DONE.
//   DONE
//     - out_valid=1; out_sum/out_cout/out_ovf stable and unchanged.
//     - On out_ready: go to IDLE, clear out_valid.
//   Latency
//     - Accept edge -> out_valid high after exactly NDIG+1 clocks.
//     - Throughput is one result per NDIG+2 cycles when out_ready is tied high.
//   No accept is possible in DONE, even if out_ready and in_valid are both high. Enforced bubble: in_ready rises the cycle after hand-off.
//   Input operands are sampled only on the accept edge; later changes to in_a/in_b/in_cin are ignored.
//   out_sum holds its last value in IDLE. In RUN it holds a partial value; the consumer must qualify it with out_valid.
//   Backpressure: DONE holds indefinitely while out_ready=0.
//   Reset in RUN or DONE aborts the operation: the result is discarded and out_valid is never raised.
//   The counter width is $clog2(NDIG) with a minimum of 1. When NDIG=1, RUN lasts exactly one cycle.
// CONFIGURATION
//   SERIAL_ADDER_SUB_EN
//     - Defined:
//         * adds port in_sub (in, 1), sampled at accept;
//         * when in_sub=1, B is inverted on load and carry := 1 (in_cin ignored), giving A-B;
//         * out_cout = 1 means no borrow; out_ovf = signed subtract overflow.
//     - Undefined: the in_sub port does not exist; the block adds only; no extra logic.
// TESTING (WIDTH=8 unless stated)
//   1. Wrap: A=0xFF, B=0x01, cin=0, DIGIT=1 -> after 9 clks out_sum=0x00, cout=1, ovf=0.
//   2. Signed overflow: A=0x7F, B=0x01, cin=0 -> sum=0x80, cout=0, ovf=1.
//      Also A=0x80, B=0x80 -> sum=0x00, cout=1, ovf=1.
//   3. Backpressure: A=0x12, B=0x34, cin=1, out_ready=0 for 20 clks -> sum=0x47 held.
//      in_ready=0 throughout; one out_ready pulse -> IDLE; in_ready=1 on the next cycle.
//   4. Reset mid-op: assert rst in 3rd RUN cycle -> next cycle all outputs 0 and in_ready=1.
//      out_valid never pulses for the aborted op.
//   5. DIGIT=4: A=0x9C, B=0x65, cin=1 -> sum=0x02, cout=1, ovf=0, out_valid 3 clks after accept.
//   6. SERIAL_ADDER_SUB_EN defined: in_sub=1, A=0x05, B=0x07 -> sum=0xFE, cout=0, ovf=0.
//      in_sub=1, A=0x80, B=0x01 -> sum=0x7F, cout=1, ovf=1.

Source files
------------

// File: rtl/serial_adder_hs.sv
// Digit-serial adder with valid/ready handshakes on operands and result.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN (adds the in_sub port).
module serial_adder_hs #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             in_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             busy
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int DW   = DIGIT + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NDIG - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    logic [WIDTH-1:0]  b_load;
    logic              carry_load;
    logic [DW-1:0]     digit_sum;
    logic [DIGIT-1:0]  digit_s;
    logic              digit_c;
    logic [WIDTH-1:0]  sum_shift;

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction is A + ~B + 1; the caller's carry-in is ignored in that mode.
    assign b_load     = in_sub ? ~in_b : in_b;
    assign carry_load = in_sub | in_cin;
`else
    assign b_load     = in_b;
    assign carry_load = in_cin;
`endif

    assign digit_sum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + DW'(carry_q);
    assign digit_s   = digit_sum[DIGIT-1:0];
    assign digit_c   = digit_sum[DIGIT];

    // New digit enters at the MSB end so the LSB digit ends up at bit 0 after NDIG steps.
    generate
        if (DIGIT == WIDTH) begin : g_single_digit
            assign sum_shift = digit_s;
        end else begin : g_multi_digit
            assign sum_shift = {digit_s, sum_q[WIDTH-1:DIGIT]};
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    a_d     = in_a;
                    b_d     = b_load;
                    carry_d = carry_load;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = digit_c;
                sum_d   = sum_shift;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    cout_d  = digit_c;
                    // a^b^s recovers the carry into the MSB of the final digit.
                    ovf_d   = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ digit_s[DIGIT-1] ^ digit_c;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN);
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_serial_adder_hs.sv
// Bench for serial_adder_hs: DIGIT=1 and DIGIT=4 instances, vector table plus random ops.
// Subtract vectors are included when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder_hs;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sel = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_a = '0;
    logic [7:0] in_b = '0;
    logic       in_cin = 1'b0;
    logic       out_ready = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    logic       in_sub = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    logic       iv1, iv4;
    logic       rdy1, rdy4, v1, v4, c1, c4, o1, o4, b1, b4;
    logic [7:0] s1, s4;
    logic       m_rdy, m_valid, m_cout, m_ovf, m_busy;
    logic [7:0] m_sum;

    assign iv1     = in_valid & ~sel;
    assign iv4     = in_valid & sel;
    assign m_rdy   = sel ? rdy4 : rdy1;
    assign m_valid = sel ? v4 : v1;
    assign m_sum   = sel ? s4 : s1;
    assign m_cout  = sel ? c4 : c1;
    assign m_ovf   = sel ? o4 : o1;
    assign m_busy  = sel ? b4 : b1;

    serial_adder_hs #(.WIDTH(8), .DIGIT(1)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(rdy1),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
`ifdef SERIAL_ADDER_SUB_EN
        .in_sub(in_sub),
`endif
        .out_valid(v1), .out_ready(out_ready), .out_sum(s1),
        .out_cout(c1), .out_ovf(o1), .busy(b1)
    );

    serial_adder_hs #(.WIDTH(8), .DIGIT(4)) u_d4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(rdy4),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
`ifdef SERIAL_ADDER_SUB_EN
        .in_sub(in_sub),
`endif
        .out_valid(v4), .out_ready(out_ready), .out_sum(s4),
        .out_cout(c4), .out_ovf(o4), .busy(b4)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         sel;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        int         bp;
        logic [7:0] esum;
        logic       ecout;
        logic       eovf;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands (subtract = A - B with borrow).
    task automatic model(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic sub, output logic [7:0] sum, output logic cout,
                         output logic ovf);
        int ua, ub, sa, sb, full, sres;
        ua = int'(a);
        ub = int'(b);
        sa = (ua > 127) ? ua - 256 : ua;
        sb = (ub > 127) ? ub - 256 : ub;
        if (sub) begin
            full = ua - ub;
            sres = sa - sb;
            cout = (ua >= ub);
        end else begin
            full = ua + ub + int'(cin);
            sres = sa + sb + int'(cin);
            cout = (full > 255);
        end
        sum = 8'(full);
        ovf = (sres > 127) || (sres < -128);
    endtask

    task automatic run_op(input bit s, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input logic sub, input int bp,
                          input logic [7:0] esum, input logic ecout, input logic eovf,
                          input string nm);
        int nd;
        int early;
        int bad_hold;
        nd = s ? 2 : 8;
        early = 0;
        bad_hold = 0;
        @(negedge clk);
        sel = s;
        in_a = a;
        in_b = b;
        in_cin = cin;
`ifdef SERIAL_ADDER_SUB_EN
        in_sub = sub;
`endif
        in_valid = 1'b1;
        out_ready = 1'b0;
        #1;
        chk({nm, ".in_ready"}, 32'(m_rdy), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_a = 8'($urandom);
        in_b = 8'($urandom);
        in_cin = 1'($urandom);
        #1;
        chk({nm, ".busy"}, 32'({m_busy, m_rdy}), 32'b10);
        for (int j = 0; j < nd; j++) begin
            if (m_valid) early++;
            @(negedge clk);
        end
        chk({nm, ".valid_early"}, 32'(early), 32'd0);
        chk({nm, ".valid"}, 32'(m_valid), 32'd1);
        chk({nm, ".result"}, 32'({m_sum, m_cout, m_ovf}), 32'({esum, ecout, eovf}));
        for (int k = 0; k < bp; k++) begin
            @(negedge clk);
            if ({m_valid, m_rdy, m_sum, m_cout, m_ovf} !== {1'b1, 1'b0, esum, ecout, eovf})
                bad_hold++;
        end
        if (bp > 0) chk({nm, ".hold"}, 32'(bad_hold), 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        chk({nm, ".handoff"}, 32'({m_valid, m_rdy, m_sum}), 32'({1'b0, 1'b1, esum}));
        $display("txn %s dig=%0d a=%h b=%h cin=%0d sub=%0d -> sum=%h cout=%0d ovf=%0d",
                 nm, s ? 4 : 1, a, b, cin, sub, m_sum, m_cout, m_ovf);
    endtask

    initial begin
        logic [7:0] es;
        logic       ec, eo;
        logic       ra_sub;
        int         seen_valid;

        vecs.push_back('{0, 8'hFF, 8'h01, 1'b0, 1'b0, 0,  8'h00, 1'b1, 1'b0});
        vecs.push_back('{0, 8'h7F, 8'h01, 1'b0, 1'b0, 0,  8'h80, 1'b0, 1'b1});
        vecs.push_back('{0, 8'h80, 8'h80, 1'b0, 1'b0, 1,  8'h00, 1'b1, 1'b1});
        vecs.push_back('{0, 8'h12, 8'h34, 1'b1, 1'b0, 20, 8'h47, 1'b0, 1'b0});
        vecs.push_back('{1, 8'h9C, 8'h65, 1'b1, 1'b0, 0,  8'h02, 1'b1, 1'b0});
        vecs.push_back('{1, 8'h7F, 8'h01, 1'b0, 1'b0, 2,  8'h80, 1'b0, 1'b1});
`ifdef SERIAL_ADDER_SUB_EN
        vecs.push_back('{0, 8'h05, 8'h07, 1'b0, 1'b1, 0,  8'hFE, 1'b0, 1'b0});
        vecs.push_back('{0, 8'h80, 8'h01, 1'b1, 1'b1, 0,  8'h7F, 1'b1, 1'b1});
        vecs.push_back('{1, 8'h05, 8'h07, 1'b1, 1'b1, 0,  8'hFE, 1'b0, 1'b0});
`endif

        // Reset behaviour
        repeat (3) @(negedge clk);
        chk("rst.in_ready_low", 32'({rdy1, rdy4}), 32'b00);
        rst = 1'b0;
        #1;
        chk("rst.outputs", 32'({v1, c1, o1, b1, s1, v4, c4, o4, b4, s4}), 32'd0);
        chk("rst.in_ready_high", 32'({rdy1, rdy4}), 32'b11);

        foreach (vecs[i]) begin
            run_op(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, vecs[i].bp,
                   vecs[i].esum, vecs[i].ecout, vecs[i].eovf, $sformatf("vec%0d", i));
        end

        // Reset while in the third RUN cycle aborts the operation
        run_op(0, 8'hFF, 8'hFF, 1'b1, 1'b0, 0, 8'hFF, 1'b1, 1'b0, "pre_abort");
        @(negedge clk);
        sel = 1'b0;
        in_a = 8'hF0;
        in_b = 8'h0F;
        in_cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        in_sub = 1'b0;
`endif
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort.in_run", 32'(b1), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort.outputs", 32'({v1, s1, c1, o1, b1}), 32'd0);
        chk("abort.in_ready", 32'(rdy1), 32'd1);
        seen_valid = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (v1) seen_valid++;
        end
        chk("abort.no_valid", 32'(seen_valid), 32'd0);
        $display("txn abort dig=1 a=f0 b=0f reset in RUN cycle 3");

        // Randomized operations against the arithmetic model
        for (int r = 0; r < 40; r++) begin
            logic       rs;
            logic [7:0] ra, rb;
            logic       rc;
            int         rbp;
            rs  = 1'($urandom);
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rc  = 1'($urandom);
            rbp = int'($urandom_range(0, 3));
`ifdef SERIAL_ADDER_SUB_EN
            ra_sub = 1'($urandom);
`else
            ra_sub = 1'b0;
`endif
            model(ra, rb, rc, ra_sub, es, ec, eo);
            run_op(rs, ra, rb, rc, ra_sub, rbp, es, ec, eo, $sformatf("rnd%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
